// File: rtl/borrow_serial_sub_if.sv
// Handshake and operand/result bundle for the serial borrow subtractor.
// The master drives operands and result acceptance; the slave is the subtractor.
interface borrow_serial_sub_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );
endinterface

// File: rtl/borrow_serial_sub.sv
// Serial subtractor: d = a - b - bin, one CHUNK-bit slice per clock from the LSB,
// with the borrow rippling between slices through a register.
module borrow_serial_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  borrow_serial_sub_if.slave    bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bout_q, ovf_q;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   diff;
  logic             last;
  logic             accept;

  assign a_slice = a_q[int'(cnt_q) * CHUNK +: CHUNK];
  assign b_slice = b_q[int'(cnt_q) * CHUNK +: CHUNK];
  // One extra bit so the MSB of the difference is the outgoing borrow.
  assign diff    = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow_q};
  assign last    = (cnt_q == CW'(N - 1));
  assign accept  = (state_q == IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      cnt_q    <= '0;
      borrow_q <= bus.bin;
    end else if (state_q == RUN) begin
      d_q[int'(cnt_q) * CHUNK +: CHUNK] <= diff[CHUNK-1:0];
      borrow_q <= diff[CHUNK];
      if (last) begin
        // Signed overflow only when operand signs differ and the result sign leaves a's.
        bout_q <= diff[CHUNK];
        ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[CHUNK-1] != a_q[WIDTH-1]);
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_borrow_serial_sub.sv
// Directed bench for borrow_serial_sub: vector table plus back-pressure and
// mid-operation reset sequences, all expectations hand-computed.
module tb_borrow_serial_sub;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  borrow_serial_sub_if #(.WIDTH(32)) bus ();

  borrow_serial_sub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] exp_d;
    logic        exp_bout;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Called at a negedge with the DUT idle; returns after out_valid is seen (or timeout).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          output int lat);
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.bin = ~bin;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[9];
    int   lat;
    logic [31:0] d_hold;

    n_pass = 0;
    n_total = 0;
    vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h00010000, 32'h00000000, 1'b1, 32'h0000FFFF, 1'b0, 1'b0};
    vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vecs[6] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[8] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_d",         bus.d,              32'd0);
    chk("reset_bout_ovf",  {30'd0, bus.bout, bus.ovf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Table vectors with out_ready held high: DONE lasts exactly one cycle.
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_d", i), bus.d, vecs[i].exp_d);
      chk($sformatf("v%0d_bout", i), 32'(bus.bout), 32'(vecs[i].exp_bout));
      chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
      chk($sformatf("v%0d_in_ready_done", i), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid_drop", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("v%0d_in_ready_back", i), 32'(bus.in_ready), 32'd1);
      $display("vec %0d: a=%h b=%h bin=%0d -> d=%h bout=%0d ovf=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].bin, bus.d, bus.bout, bus.ovf, lat);
      @(negedge clk);
    end

    // Back-pressure: result held for 3 cycles while a stray operand is offered.
    bus.out_ready = 1'b0;
    start_op(32'h00000005, 32'h00000003, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    d_hold = bus.d;
    chk("bp_d_first", d_hold, 32'h00000002);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.a = 32'h12345678; bus.b = 32'h0; bus.bin = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_d", c), bus.d, 32'h00000002);
      chk($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_bout", c), 32'(bus.bout), 32'd0);
      chk($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_stray_accept", 32'(bus.out_valid), 32'd0);
    chk("bp_still_idle",      32'(bus.in_ready),  32'd1);
    $display("backpressure: d=%h held 3 cycles, stray operand ignored", d_hold);
    @(negedge clk);

    // Reset asserted during the 2nd RUN cycle; slice 0 (0x78-0x01) already written.
    bus.a = 32'h12345678; bus.b = 32'h00000001; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_d",         bus.d,              32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_bout",      32'(bus.bout),      32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start_op(32'h00000010, 32'h00000001, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_d",       bus.d,    32'h0000000F);
    $display("post-reset op: d=%h lat=%0d", bus.d, lat);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
